// File: rtl/winograd_data_controller.sv
// Walks the overlapping Winograd input tiles of one depth slice. Each tile is fetched from
// the feature buffer one element per cycle and handed to the PE array over valid/ready.
module winograd_data_controller #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int LINE_W    = 64,
  parameter int CH_STRIDE = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_prepare_i,
  input  logic [7:0]            block_width_i,
  input  logic [7:0]            block_height_i,
  input  logic [3:0]            data_id_i,
  input  logic                  size_type_i,
  output logic                  loop_finished_o,
  output logic                  rd_en_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic [DATA_W-1:0]     rd_data_i,
  output logic                  tile_valid_o,
  input  logic                  tile_ready_i,
  output logic [36*DATA_W-1:0]  tile_data_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {IDLE, FETCH, EMIT, DONE, WAIT_LOW} state_t;
  state_t state, state_nxt;

  logic [7:0]            blk_w, blk_h, tile_row, tile_col;
  logic [3:0]            data_id;
  logic                  size_type;
  logic [2:0]            fi, fj;
  logic                  issue_done;
  logic                  cap_vld;
  logic [5:0]            cap_idx;
  logic [36*DATA_W-1:0]  tile_reg;
  logic [2:0]            n_m1;
  logic [2:0]            step;
  logic                  last_tile;
  logic [ADDR_W-1:0]     addr_calc;

  assign n_m1      = size_type ? 3'd5 : 3'd3;
  assign step      = size_type ? 3'd4 : 3'd2;
  assign last_tile = (tile_col == blk_w - 8'd1) && (tile_row == blk_h - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (data_prepare_i) state_nxt = FETCH;
      // issue_done marks the cycle in which the last element is being captured
      FETCH:    if (issue_done) state_nxt = EMIT;
      EMIT:     if (tile_ready_i) state_nxt = last_tile ? DONE : FETCH;
      DONE:     state_nxt = WAIT_LOW;
      WAIT_LOW: if (!data_prepare_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en_o         = 1'b0;
    tile_valid_o    = 1'b0;
    loop_finished_o = 1'b0;
    busy_o          = 1'b1;
    case (state)
      IDLE:    busy_o = 1'b0;
      FETCH:   rd_en_o = !issue_done;
      EMIT:    tile_valid_o = 1'b1;
      DONE:    loop_finished_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_calc = ADDR_W'(32'(data_id) * 32'(CH_STRIDE)
                      + (32'(tile_row) * 32'(step) + 32'(fi)) * 32'(LINE_W)
                      + 32'(tile_col) * 32'(step) + 32'(fj));
  end

  assign rd_addr_o = rd_en_o ? addr_calc : '0;

  // F(2,3) tiles only occupy the low 16 elements; the rest always read as zero
  assign tile_data_o = size_type ? tile_reg
                                 : {{(20*DATA_W){1'b0}}, tile_reg[16*DATA_W-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_w      <= '0;
      blk_h      <= '0;
      data_id    <= '0;
      size_type  <= 1'b0;
      tile_row   <= '0;
      tile_col   <= '0;
      fi         <= '0;
      fj         <= '0;
      issue_done <= 1'b0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      tile_reg   <= '0;
    end else begin
      cap_vld <= rd_en_o;
      cap_idx <= 6'(fi) * (size_type ? 6'd6 : 6'd4) + 6'(fj);
      if (cap_vld) tile_reg[32'(cap_idx)*DATA_W +: DATA_W] <= rd_data_i;

      case (state)
        IDLE: begin
          if (data_prepare_i) begin
            blk_w      <= (block_width_i  == 8'd0) ? 8'd1 : block_width_i;
            blk_h      <= (block_height_i == 8'd0) ? 8'd1 : block_height_i;
            data_id    <= data_id_i;
            size_type  <= size_type_i;
            tile_row   <= '0;
            tile_col   <= '0;
            fi         <= '0;
            fj         <= '0;
            issue_done <= 1'b0;
          end
        end
        FETCH: begin
          if (!issue_done) begin
            if (fj == n_m1) begin
              fj <= '0;
              if (fi == n_m1) begin
                fi         <= '0;
                issue_done <= 1'b1;
              end else begin
                fi <= fi + 3'd1;
              end
            end else begin
              fj <= fj + 3'd1;
            end
          end
        end
        EMIT: begin
          if (tile_ready_i) begin
            issue_done <= 1'b0;
            if (!last_tile) begin
              if (tile_col == blk_w - 8'd1) begin
                tile_col <= '0;
                tile_row <= tile_row + 8'd1;
              end else begin
                tile_col <= tile_col + 8'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_data_controller.sv
// Bench for winograd_data_controller: random buffer contents and random ready, checked
// against a tile-walk reference model computed directly from the tiling arithmetic.
module tb_winograd_data_controller;
  localparam int DATA_W = 8, ADDR_W = 16, LINE_W = 64, CH_STRIDE = 4096;
  localparam int TW = 36 * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              data_prepare_i = 1'b0;
  logic [7:0]        block_width_i = '0, block_height_i = '0;
  logic [3:0]        data_id_i = '0;
  logic              size_type_i = 1'b0;
  logic              loop_finished_o, rd_en_o, tile_valid_o, busy_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i = '0;
  logic              tile_ready_i = 1'b0;
  logic [TW-1:0]     tile_data_o;

  winograd_data_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W),
                             .CH_STRIDE(CH_STRIDE)) dut (
    .clk(clk), .reset(reset), .data_prepare_i(data_prepare_i),
    .block_width_i(block_width_i), .block_height_i(block_height_i),
    .data_id_i(data_id_i), .size_type_i(size_type_i),
    .loop_finished_o(loop_finished_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .tile_data_o(tile_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:65535];
  always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  int total = 0, bad = 0;
  logic [ADDR_W-1:0] rd_q[$], exp_addr[$];
  logic [TW-1:0]     tile_q[$], exp_tile[$];
  int pulse_cnt = 0, tiles_at_pulse = 0;

  always @(negedge clk) begin
    if (rd_en_o) rd_q.push_back(rd_addr_o);
    if (tile_valid_o && tile_ready_i) tile_q.push_back(tile_data_o);
    if (loop_finished_o) begin
      pulse_cnt++;
      tiles_at_pulse = tile_q.size();
    end
  end

  task automatic clear_mon();
    rd_q.delete(); tile_q.delete(); pulse_cnt = 0; tiles_at_pulse = 0;
  endtask

  // Reference: tiles in row-major order, each an N x N window stepping by STEP
  task automatic build_model(input int w, input int h, input int id, input int sz);
    int n, st;
    logic [TW-1:0] t;
    logic [ADDR_W-1:0] a;
    exp_addr.delete(); exp_tile.delete();
    if (w == 0) w = 1;
    if (h == 0) h = 1;
    n  = sz ? 6 : 4;
    st = sz ? 4 : 2;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        t = '0;
        for (int i = 0; i < n; i++)
          for (int j = 0; j < n; j++) begin
            a = ADDR_W'(id * CH_STRIDE + (r * st + i) * LINE_W + c * st + j);
            exp_addr.push_back(a);
            t[(i * n + j) * DATA_W +: DATA_W] = mem[a];
          end
        exp_tile.push_back(t);
      end
  endtask

  task automatic start_job(input int w, input int h, input int id, input int sz);
    block_width_i  = 8'(w);
    block_height_i = 8'(h);
    data_id_i      = 4'(id);
    size_type_i    = 1'(sz);
    data_prepare_i = 1'b1;
  endtask

  task automatic finish_job(input bit rnd_rdy, input bit hold_prep, output bit timeout);
    int c = 0;
    while (!loop_finished_o && c < 6000) begin
      @(posedge clk); #1;
      tile_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      c++;
    end
    timeout = !loop_finished_o;
    if (!hold_prep) begin
      data_prepare_i = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
    tile_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin @(posedge clk); #1; end
    total++; if (rd_en_o !== 1'b0) begin bad++; $display("FAIL reset_rd_en got %b want 0", rd_en_o); end
    total++; if (rd_addr_o !== '0) begin bad++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr_o); end
    total++; if (tile_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", tile_valid_o); end
    total++; if (tile_data_o !== '0) begin bad++; $display("FAIL reset_data got %h want 0", tile_data_o); end
    total++; if (loop_finished_o !== 1'b0) begin bad++; $display("FAIL reset_finished got %b want 0", loop_finished_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile();
    int lat = 0;
    clear_mon();
    build_model(1, 1, 0, 0);
    tile_ready_i = 1'b1;
    start_job(1, 1, 0, 0);
    @(posedge clk); #1;
    total++; if (rd_en_o !== 1'b1 || rd_addr_o !== '0) begin bad++; $display("FAIL single_first_read got en=%b addr=%0d want en=1 addr=0", rd_en_o, rd_addr_o); end
    while (!tile_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 17) begin bad++; $display("FAIL single_latency got %0d want 17", lat); end
    total++; if (tile_data_o !== exp_tile[0]) begin bad++; $display("FAIL single_tile got %h want %h", tile_data_o, exp_tile[0]); end
    @(posedge clk); #1;
    total++; if (loop_finished_o !== 1'b1) begin bad++; $display("FAIL single_pulse got %b want 1", loop_finished_o); end
    data_prepare_i = 1'b0;
    @(posedge clk); #1;
    total++; if (loop_finished_o !== 1'b0) begin bad++; $display("FAIL single_pulse_width got %b want 0", loop_finished_o); end
    @(posedge clk); #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_idle got busy=%b want 0", busy_o); end
    total++; if (pulse_cnt != 1) begin bad++; $display("FAIL single_pulse_count got %0d want 1", pulse_cnt); end
    total++; if (rd_q.size() != 16) begin bad++; $display("FAIL single_reads got %0d want 16", rd_q.size()); end
    for (int k = 0; k < 16 && k < rd_q.size(); k++) begin
      total++; if (rd_q[k] !== exp_addr[k]) begin bad++; $display("FAIL single_addr[%0d] got %0d want %0d", k, rd_q[k], exp_addr[k]); end
    end
    tile_ready_i = 1'b0;
  endtask

  task automatic test_big_tiles();
    bit to;
    int base [4] = '{12288, 12292, 12544, 12548};
    clear_mon();
    build_model(2, 2, 3, 1);
    start_job(2, 2, 3, 1);
    finish_job(1'b0, 1'b0, to);
    total++; if (to) begin bad++; $display("FAIL big_timeout got no pulse want pulse"); end
    total++; if (rd_q.size() != 144) begin bad++; $display("FAIL big_reads got %0d want 144", rd_q.size()); end
    for (int t = 0; t < 4 && 36 * t < rd_q.size(); t++) begin
      total++; if (rd_q[36 * t] !== ADDR_W'(base[t])) begin bad++; $display("FAIL big_base[%0d] got %0d want %0d", t, rd_q[36 * t], base[t]); end
    end
    for (int k = 0; k < exp_addr.size() && k < rd_q.size(); k++) begin
      total++; if (rd_q[k] !== exp_addr[k]) begin bad++; $display("FAIL big_addr[%0d] got %0d want %0d", k, rd_q[k], exp_addr[k]); end
    end
    for (int k = 0; k < exp_tile.size() && k < tile_q.size(); k++) begin
      total++; if (tile_q[k] !== exp_tile[k]) begin bad++; $display("FAIL big_tile[%0d] got %h want %h", k, tile_q[k], exp_tile[k]); end
    end
    total++; if (tiles_at_pulse != 4 || pulse_cnt != 1) begin bad++; $display("FAIL big_pulse got tiles=%0d pulses=%0d want 4 1", tiles_at_pulse, pulse_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    int c = 0;
    logic [TW-1:0] snap;
    clear_mon();
    build_model(2, 1, 7, 0);
    tile_ready_i = 1'b0;
    start_job(2, 1, 7, 0);
    while (!tile_valid_o && c < 200) begin @(posedge clk); #1; c++; end
    snap = tile_data_o;
    total++; if (snap !== exp_tile[0]) begin bad++; $display("FAIL bp_tile got %h want %h", snap, exp_tile[0]); end
    repeat (10) begin
      @(posedge clk); #1;
      total++;
      if (tile_valid_o !== 1'b1 || tile_data_o !== snap || rd_en_o !== 1'b0) begin
        bad++; $display("FAIL bp_hold got valid=%b en=%b stable=%b want 1 0 1", tile_valid_o, rd_en_o, tile_data_o === snap);
      end
    end
    tile_ready_i = 1'b1;
    @(posedge clk); #1;
    total++; if (tile_valid_o !== 1'b0 || rd_en_o !== 1'b1) begin bad++; $display("FAIL bp_advance got valid=%b en=%b want 0 1", tile_valid_o, rd_en_o); end
    finish_job(1'b0, 1'b0, to);
    total++; if (to || tile_q.size() != 2) begin bad++; $display("FAIL bp_done got timeout=%b tiles=%0d want 0 2", to, tile_q.size()); end
    if (tile_q.size() == 2) begin
      total++; if (tile_q[1] !== exp_tile[1]) begin bad++; $display("FAIL bp_tile2 got %h want %h", tile_q[1], exp_tile[1]); end
    end
  endtask

  task automatic test_handshake();
    bit to;
    clear_mon();
    start_job(1, 1, 5, 0);
    finish_job(1'b1, 1'b1, to);
    total++; if (to) begin bad++; $display("FAIL hs_timeout got no pulse want pulse"); end
    repeat (20) begin
      @(posedge clk); #1;
      total++;
      if (busy_o !== 1'b1 || loop_finished_o !== 1'b0 || rd_en_o !== 1'b0) begin
        bad++; $display("FAIL hs_wait_low got busy=%b fin=%b en=%b want 1 0 0", busy_o, loop_finished_o, rd_en_o);
      end
    end
    total++; if (pulse_cnt != 1 || rd_q.size() != 16) begin bad++; $display("FAIL hs_no_restart got pulses=%0d reads=%0d want 1 16", pulse_cnt, rd_q.size()); end
    data_prepare_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL hs_idle got busy=%b want 0", busy_o); end
    start_job(1, 1, 5, 0);
    finish_job(1'b1, 1'b0, to);
    total++; if (to || pulse_cnt != 2 || rd_q.size() != 32) begin bad++; $display("FAIL hs_second_job got pulses=%0d reads=%0d want 2 32", pulse_cnt, rd_q.size()); end
  endtask

  task automatic test_zero_dims();
    bit to;
    clear_mon();
    build_model(0, 0, 2, 1);
    start_job(0, 0, 2, 1);
    finish_job(1'b1, 1'b0, to);
    total++; if (to || pulse_cnt != 1) begin bad++; $display("FAIL zero_pulse got timeout=%b pulses=%0d want 0 1", to, pulse_cnt); end
    total++; if (rd_q.size() != 36 || tile_q.size() != 1) begin bad++; $display("FAIL zero_count got reads=%0d tiles=%0d want 36 1", rd_q.size(), tile_q.size()); end
    if (tile_q.size() == 1) begin
      total++; if (tile_q[0] !== exp_tile[0]) begin bad++; $display("FAIL zero_tile got %h want %h", tile_q[0], exp_tile[0]); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit to;
    int c = 0;
    clear_mon();
    tile_ready_i = 1'b1;
    start_job(2, 2, 1, 0);
    while (rd_q.size() < 21 && c < 300) begin @(posedge clk); #1; c++; end
    total++; if (rd_en_o !== 1'b1) begin bad++; $display("FAIL rst_mid_setup got en=%b want 1", rd_en_o); end
    reset = 1'b1; data_prepare_i = 1'b0; tile_ready_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rd_en_o !== 1'b0 || rd_addr_o !== '0 || tile_valid_o !== 1'b0 || tile_data_o !== '0 ||
        loop_finished_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_outputs got en=%b addr=%0d valid=%b data_zero=%b fin=%b busy=%b want all 0",
                      rd_en_o, rd_addr_o, tile_valid_o, tile_data_o === '0, loop_finished_o, busy_o);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    build_model(2, 2, 1, 0);
    start_job(2, 2, 1, 0);
    finish_job(1'b1, 1'b0, to);
    total++; if (to || rd_q.size() != 64 || tile_q.size() != 4) begin bad++; $display("FAIL rst_restart got timeout=%b reads=%0d tiles=%0d want 0 64 4", to, rd_q.size(), tile_q.size()); end
    for (int k = 0; k < exp_addr.size() && k < rd_q.size(); k++) begin
      total++; if (rd_q[k] !== exp_addr[k]) begin bad++; $display("FAIL rst_addr[%0d] got %0d want %0d", k, rd_q[k], exp_addr[k]); end
    end
    for (int k = 0; k < exp_tile.size() && k < tile_q.size(); k++) begin
      total++; if (tile_q[k] !== exp_tile[k]) begin bad++; $display("FAIL rst_tile[%0d] got %h want %h", k, tile_q[k], exp_tile[k]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int w, h, id, sz;
    for (int it = 0; it < 6; it++) begin
      w  = $urandom_range(0, 3);
      h  = $urandom_range(0, 3);
      id = $urandom_range(0, 15);
      sz = $urandom_range(0, 1);
      clear_mon();
      build_model(w, h, id, sz);
      start_job(w, h, id, sz);
      @(posedge clk); #1;
      // descriptor and prepare wiggle after the job is latched
      block_width_i  = 8'($urandom);
      block_height_i = 8'($urandom);
      data_id_i      = 4'($urandom);
      size_type_i    = 1'($urandom);
      data_prepare_i = 1'($urandom_range(0, 1));
      finish_job(1'b1, 1'b0, to);
      total++; if (to || pulse_cnt != 1) begin bad++; $display("FAIL rnd%0d_pulse got timeout=%b pulses=%0d want 0 1", it, to, pulse_cnt); end
      total++; if (rd_q.size() != exp_addr.size() || tile_q.size() != exp_tile.size()) begin
        bad++; $display("FAIL rnd%0d_count got reads=%0d tiles=%0d want %0d %0d", it, rd_q.size(), tile_q.size(), exp_addr.size(), exp_tile.size());
      end
      for (int k = 0; k < exp_addr.size() && k < rd_q.size(); k++) begin
        total++; if (rd_q[k] !== exp_addr[k]) begin bad++; $display("FAIL rnd%0d_addr[%0d] got %0d want %0d", it, k, rd_q[k], exp_addr[k]); end
      end
      for (int k = 0; k < exp_tile.size() && k < tile_q.size(); k++) begin
        total++; if (tile_q[k] !== exp_tile[k]) begin bad++; $display("FAIL rnd%0d_tile[%0d] got %h want %h", it, k, tile_q[k], exp_tile[k]); end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = DATA_W'(a);
    test_reset();
    test_single_tile();
    for (int a = 0; a < 65536; a++) mem[a] = DATA_W'($urandom);
    test_big_tiles();
    test_backpressure();
    test_handshake();
    test_zero_dims();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/winograd_data_controller.md
Name: winograd_data_controller

Overview:
- Data-side counterpart of the main controller: consumes its job descriptor (block_width, block_height, data_id, size_type, data_prepare) and returns the loop_finished pulse.
- Per job, walks every overlapping Winograd input tile of one input-depth slice (data_id) and fetches it element by element from the on-chip feature buffer.
- Hands each assembled tile to the PE array over a valid/ready interface.

Parameters:
- DATA_W, 8, element width in bits
- ADDR_W, 16, feature buffer address width
- LINE_W, 64, elements per feature-map row in the buffer (row stride)
- CH_STRIDE, 4096, address offset between consecutive input-depth slices

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_prepare_i  in  1  job request from main controller; level, not pulse
- block_width_i  in  8  tiles per row
- block_height_i  in  8  tile rows
- data_id_i  in  4  input-depth slice index
- size_type_i  in  1  0: F(2,3), 4x4 tile, step 2; 1: F(4,3), 6x6 tile, step 4
- loop_finished_o  out  1  one-cycle pulse, job done
- rd_en_o  out  1  feature buffer read strobe
- rd_addr_o  out  ADDR_W  feature buffer read address
- rd_data_i  in  DATA_W  read data, valid exactly 1 cycle after rd_en_o
- tile_valid_o  out  1  tile available
- tile_ready_i  in  1  PE array accepts tile
- tile_data_o  out  36*DATA_W  tile; element k=i*N+j at bits [k*DATA_W +: DATA_W]
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync): state IDLE; all outputs 0; tile register cleared; counters 0.
- Derived values: N=4, STEP=2 for size 0; N=6, STEP=4 for size 1.
- States: IDLE, FETCH, EMIT, DONE, WAIT_LOW.
- IDLE:
  - When data_prepare_i=1, latch block_width_i, block_height_i, data_id_i, size_type_i.
  - Latched block_width or block_height of 0 is treated as 1.
  - Clear tile_row/tile_col counters and go to FETCH.
  - Later changes on descriptor inputs are ignored until the next IDLE.
- FETCH:
  - Issue N*N consecutive reads, one per cycle, i outer and j inner, both 0..N-1.
  - rd_addr_o = data_id*CH_STRIDE + (tile_row*STEP+i)*LINE_W + tile_col*STEP+j, truncated to ADDR_W.
  - rd_data_i is captured one cycle after each strobe into element i*N+j.
  - For size 0, elements 16..35 read as 0.
  - Transition to EMIT in the cycle after the last capture.
  - Tile fetch latency: N*N+1 cycles from FETCH entry to tile_valid_o=1 (17 or 37 cycles).
- EMIT:
  - tile_valid_o=1 with tile_data_o held stable until tile_ready_i=1.
  - On handshake, if tile_col=block_width-1 and tile_row=block_height-1, go to DONE.
  - Otherwise advance tile_col (wrapping to 0 and incrementing tile_row) and go to FETCH.
  - tile_valid_o drops in the cycle after the handshake.
  - tile_ready_i high before valid has no effect.
- DONE: loop_finished_o=1 for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW:
  - Wait for data_prepare_i=0, then go to IDLE.
  - Reason: the main controller holds prepare high until it sees the pulse, then drops it for at least one cycle, so the same job cannot restart.
  - If data_prepare_i stays 1, remain in WAIT_LOW; no second pulse is issued.
- Mid-job deassertion: data_prepare_i dropping during FETCH/EMIT is ignored; the job completes.
- Simultaneous reset and any event: reset wins.
- Reset mid-FETCH: the in-flight read is discarded and no capture occurs.
- rd_en_o is 0 outside FETCH.
- Total tiles per job = block_width*block_height, up to 255*255; counters are 8 bits each.

Test Plan:
- Size 0, width=1, height=1, data_id=0, buffer[a]=a&0xFF, ready tied 1 -> 16 reads at addrs 0,1,2,3,64,65,...,195; tile elements 0..15 = 0,1,2,3,64,...,195 (low byte), elements 16..35 = 0; valid at cycle 17 after FETCH entry; single loop_finished pulse.
- Size 1, width=2, height=2, data_id=3 -> 4 tiles with base addresses 12288, 12292, 12544, 12548; 36 reads each; pulse only after the 4th handshake.
- Backpressure: tile_ready_i held 0 for 10 cycles during EMIT -> tile_valid_o and tile_data_o stable for all 10 cycles; no rd_en_o; advance occurs only on the ready cycle.
- Handshake with main controller model (prepare drops 1 cycle after pulse, then rises) -> exactly one job per prepare window; data_prepare_i held high after the pulse -> stays in WAIT_LOW, no restart.
- Descriptor block_width=0, block_height=0 -> treated as 1x1; one tile, one pulse.
- Reset asserted mid-FETCH of tile 2 of 4 -> next cycle IDLE with all outputs 0; a fresh job restarts from tile (0,0) with correct addresses.
